// File: rtl/axi_slave_lite_regs.sv
// AXI4-Lite slave with seven read/write words and one read-only status word (word 7).
// Build option: define AXIL_SLV_RESP_ERR_EN to answer writes to word 7 with SLVERR instead of OKAY.
module axi_slave_lite_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   CTRL_O,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   STATUS_I
);

    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    logic                          r_live;
    logic                          r_aw_done, r_w_done;
    logic [2:0]                    r_aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]                 r_wstrb;
    logic [1:0]                    r_bresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [0:7];

    logic                          w_awready, w_wready, w_arready;
    logic                          w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [2:0]                    w_wr_idx, w_rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_data, w_rd_mux;
    logic [NB-1:0]                 w_wr_strb;
    logic [1:0]                    w_bresp_nxt;
    logic                          w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = r_live & ~r_aw_done;
                w_wready  = r_live & ~r_w_done;
                w_commit  = (r_aw_done | (S_AXI_AWVALID & w_awready)) &
                            (r_w_done  | (S_AXI_WVALID  & w_wready));
                if (w_commit)
                    w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_BREADY)
                    w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = r_live;
                if (S_AXI_ARVALID & w_arready)
                    w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (S_AXI_RREADY)
                    w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign w_aw_hs   = S_AXI_AWVALID & w_awready;
    assign w_w_hs    = S_AXI_WVALID & w_wready;
    assign w_ar_hs   = S_AXI_ARVALID & w_arready;
    // A channel captured this very edge bypasses its holding register.
    assign w_wr_idx  = w_aw_hs ? S_AXI_AWADDR[4:2] : r_aw_idx;
    assign w_wr_data = w_w_hs ? S_AXI_WDATA : r_wdata;
    assign w_wr_strb = w_w_hs ? S_AXI_WSTRB : r_wstrb;
    assign w_rd_idx  = S_AXI_ARADDR[4:2];
    assign w_rd_mux  = (w_rd_idx == 3'd7) ? STATUS_I : r_regs[w_rd_idx];

`ifdef AXIL_SLV_RESP_ERR_EN
    assign w_bresp_nxt = (w_wr_idx == 3'd7) ? 2'b10 : 2'b00;
`else
    assign w_bresp_nxt = 2'b00;
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_live    <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= 2'b00;
            r_rdata   <= '0;
            for (int i = 0; i < 8; i++)
                r_regs[i] <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[4:2];
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_bresp   <= w_bresp_nxt;
                if (w_wr_idx != 3'd7) begin
                    for (int b = 0; b < NB; b++)
                        if (w_wr_strb[b])
                            r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
            // Sampled from the pre-commit array, so a colliding write is not yet visible.
            if (w_ar_hs)
                r_rdata <= w_rd_mux;
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_BVALID  = (r_wstate == W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = (r_rstate == R_DATA);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign CTRL_O        = r_regs[0];

endmodule

// File: tb/tb_axi_slave_lite_regs.sv
// Scoreboard bench for axi_slave_lite_regs: expected B/R responses are queued at issue
// and checked by a negedge monitor when the matching handshake is seen.
module tb_axi_slave_lite_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, ctrl, status;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    logic [1:0]  q_b[$];
    logic [31:0] q_r[$];
    logic [31:0] mdl [0:7];
    int          n_tests = 0;
    int          n_fail  = 0;

`ifdef AXIL_SLV_RESP_ERR_EN
    localparam logic [1:0] EXP_ST_RESP = 2'b10;
`else
    localparam logic [1:0] EXP_ST_RESP = 2'b00;
`endif

    always #5 clk = ~clk;

    axi_slave_lite_regs dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .CTRL_O       (ctrl),
        .STATUS_I     (status)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                if (q_b.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
                else                 chk("bresp", {30'b0, bresp}, {30'b0, q_b.pop_front()});
            end
            if (rvalid && rready) begin
                if (q_r.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
                else begin
                    chk("rdata", rdata, q_r.pop_front());
                    chk("rresp", {30'b0, rresp}, 32'd0);
                end
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic mdl_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a[4:2] != 3'd7) mdl[a[4:2]] = merge(mdl[a[4:2]], d, s);
    endtask

    // Caller is always 1 time unit after a rising edge.
    task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input logic [1:0] resp);
        q_b.push_back(resp);
        fork
            begin
                int n;
                n = 0;
                repeat (aw_dly) @(posedge clk);
                #1 awaddr = a; awvalid = 1'b1;
                @(negedge clk);
                while (!awready && n < 50) begin @(negedge clk); n++; end
                if (n >= 50) chk("aw_timeout", 32'd0, 32'd1);
                @(posedge clk);
                #1 awvalid = 1'b0;
            end
            begin
                int n;
                n = 0;
                repeat (w_dly) @(posedge clk);
                #1 wdata = d; wstrb = s; wvalid = 1'b1;
                @(negedge clk);
                while (!wready && n < 50) begin @(negedge clk); n++; end
                if (n >= 50) chk("w_timeout", 32'd0, 32'd1);
                @(posedge clk);
                #1 wvalid = 1'b0;
            end
        join
        chk("b_latency", {31'b0, bvalid}, 32'd1);
    endtask

    task automatic wait_b();
        int n;
        n = 0;
        while (q_b.size() != 0 && n < 100) begin @(posedge clk); n++; end
        if (n >= 100) chk("b_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic axi_rd(input logic [4:0] a, input logic [31:0] exp);
        int n;
        n = 0;
        q_r.push_back(exp);
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("ar_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        chk("r_latency", {31'b0, rvalid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        int          n;
        rst = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0;
        rready = 1'b1; status = 32'hA5A5_0001;
        for (int i = 0; i < 8; i++) mdl[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_wready",  {31'b0, wready},  32'd0);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_bvalid",  {31'b0, bvalid},  32'd0);
        chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        chk("rst_ctrl",    ctrl,  32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_awready", {31'b0, awready}, 32'd1);
        chk("post_rst_wready",  {31'b0, wready},  32'd1);
        chk("post_rst_arready", {31'b0, arready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            a = 5'(i * 4);
            axi_rd(a, (i == 7) ? status : 32'h0);
        end

        // AW and W together
        axi_wr(5'h00, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00); mdl_wr(5'h00, 32'hDEAD_BEEF, 4'hF);
        wait_b();
        chk("ctrl_o", ctrl, 32'hDEAD_BEEF);
        axi_rd(5'h00, 32'hDEAD_BEEF);

        // W three cycles ahead of AW, partial strobe
        axi_wr(5'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00); wait_b();
        axi_wr(5'h04, 32'h1234_5678, 4'h5, 3, 0, 2'b00); wait_b();
        mdl[1] = 32'hFF34_FF78;
        axi_rd(5'h04, 32'hFF34_FF78);

        // AW ahead of W, unaligned address low bits ignored
        axi_wr(5'h0D, 32'hCAFE_F00D, 4'hF, 0, 2, 2'b00); wait_b();
        mdl_wr(5'h0C, 32'hCAFE_F00D, 4'hF);
        axi_rd(5'h0C, 32'hCAFE_F00D);
        axi_wr(5'h0C, 32'h0000_0000, 4'h0, 0, 0, 2'b00); wait_b();
        axi_rd(5'h0C, 32'hCAFE_F00D);

        // B back-pressure with a second write waiting
        bready = 1'b0;
        axi_wr(5'h10, 32'hAAAA_5555, 4'hF, 0, 0, 2'b00); mdl_wr(5'h10, 32'hAAAA_5555, 4'hF);
        awaddr = 5'h14; awvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_bvalid",  {31'b0, bvalid},  32'd1);
            chk("stall_bresp",   {30'b0, bresp},   32'd0);
            chk("stall_awready", {31'b0, awready}, 32'd0);
            chk("stall_wready",  {31'b0, wready},  32'd0);
        end
        q_b.push_back(2'b00);
        @(posedge clk);
        #1 bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("aw2_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        mdl_wr(5'h14, 32'h5555_AAAA, 4'hF);
        wait_b();
        axi_rd(5'h10, 32'hAAAA_5555);
        axi_rd(5'h14, 32'h5555_AAAA);

        // Status word: read-only
        axi_rd(5'h1C, 32'hA5A5_0001);
        axi_wr(5'h1C, 32'h1234_5678, 4'hF, 0, 0, EXP_ST_RESP); wait_b();
        axi_rd(5'h1C, 32'hA5A5_0001);
        axi_rd(5'h18, mdl[6]);
        status = 32'h0BAD_CAFE;
        axi_rd(5'h1F, 32'h0BAD_CAFE);

        // Read handshake on the same edge as a write commit to the same word
        axi_wr(5'h08, 32'h1111_1111, 4'hF, 0, 0, 2'b00); wait_b();
        fork
            axi_wr(5'h08, 32'h2222_2222, 4'hF, 0, 0, 2'b00);
            axi_rd(5'h08, 32'h1111_1111);
        join
        wait_b();
        mdl[2] = 32'h2222_2222;
        axi_rd(5'h08, 32'h2222_2222);

        for (int k = 0; k < 8; k++) begin
            a = 5'({$urandom_range(0, 6), 2'b00}) | 5'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_wr(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), 2'b00);
            mdl_wr(a, d, s);
            wait_b();
        end
        for (int i = 0; i < 8; i++) begin
            a = 5'(i * 4);
            axi_rd(a, (i == 7) ? status : mdl[i]);
        end

        // Reset while a response is pending
        bready = 1'b0;
        axi_wr(5'h00, 32'h0000_0077, 4'hF, 0, 0, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_bvalid",  {31'b0, bvalid},  32'd0);
        chk("rst_mid_ctrl",    ctrl, 32'd0);
        chk("rst_mid_awready", {31'b0, awready}, 32'd0);
        q_b.delete();
        for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
        @(posedge clk);
        #1 rst = 1'b0; bready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_no_b", {31'b0, bvalid}, 32'd0);
        axi_rd(5'h00, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_slave_lite_regs.md
AXI_SLAVE_LITE_REGS -- requirements
Module: axi_slave_lite_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (8 words).
REQ-003 SHALL have port S_AXI_ACLK, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port S_AXI_ARESET, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports S_AXI_AWADDR in [4:0], S_AXI_AWPROT in [2:0] (ignored), S_AXI_AWVALID in 1 and S_AXI_AWREADY out 1, the write address channel.
REQ-006 SHALL have ports S_AXI_WDATA in [31:0], S_AXI_WSTRB in [3:0], S_AXI_WVALID in 1 and S_AXI_WREADY out 1, the write data channel.
REQ-007 SHALL have ports S_AXI_BRESP out [1:0], S_AXI_BVALID out 1 and S_AXI_BREADY in 1, the write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR in [4:0], S_AXI_ARPROT in [2:0] (ignored), S_AXI_ARVALID in 1 and S_AXI_ARREADY out 1, the read address channel.
REQ-009 SHALL have ports S_AXI_RDATA out [31:0], S_AXI_RRESP out [1:0], S_AXI_RVALID out 1 and S_AXI_RREADY in 1, the read data channel.
REQ-010 SHALL have port CTRL_O, output, 32, live value of reg0.
REQ-011 SHALL have port STATUS_I, input, 32, sampled as read-only word 7.

Function
REQ-012 Word index SHALL be ADDR[4:2]; ADDR[1:0] ignored.
REQ-013 Words 0-6 SHALL be read/write registers; word 7 SHALL read STATUS_I and ignore writes (BRESP OKAY, no state change).
REQ-014 Write FSM SHALL have states W_IDLE, W_RESP; AW and W SHALL each be accepted independently (AWREADY=1 until AW captured, WREADY=1 until W captured), in either order or the same cycle.
REQ-015 On the edge where the second of AW/W is captured (or both together), the FSM SHALL commit the write per WSTRB byte lane, set BVALID=1, BRESP=OKAY, and enter W_RESP.
REQ-016 In W_RESP, AWREADY=WREADY=0; BVALID/BRESP SHALL hold until BREADY=1, then return to W_IDLE next cycle.
REQ-017 Read FSM SHALL have states R_IDLE (ARREADY=1), R_DATA (ARREADY=0, RVALID=1); on the AR handshake edge RDATA/RRESP SHALL be registered; RDATA/RRESP/RVALID SHALL hold until RREADY=1.
REQ-018 Read latency SHALL be 1 cycle from the AR handshake to RVALID.
REQ-019 When a read handshake and a write commit occur on the same edge at the same word, RDATA SHALL return the pre-write value.
REQ-020 WSTRB=4'b0000 SHALL complete a normal response with no register change.
REQ-021 Only one outstanding transaction per direction; read and write paths SHALL operate concurrently.

Reset
REQ-022 While S_AXI_ARESET=1 at a rising edge: regs0-6=0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, FSMs to idle, captured flags cleared.
REQ-023 AWREADY, WREADY, ARREADY SHALL go to 1 on the first edge after reset deasserts.
REQ-024 Reset mid-transaction SHALL abandon it; no response SHALL be issued for it afterwards.

Configuration
REQ-025 With macro AXIL_SLV_RESP_ERR_EN defined, writes to word 7 SHALL return BRESP=SLVERR (2'b10) with no state change; without it, BRESP=OKAY. Reads always return OKAY.

Verification
REQ-026 Write 0x00 data 0xDEADBEEF strb 0xF, AW and W same cycle -> BVALID next edge, BRESP=00, CTRL_O=0xDEADBEEF; read 0x00 -> RDATA=0xDEADBEEF one cycle after AR.
REQ-027 W presented 3 cycles before AW to 0x04 data 0x12345678 strb 0x5 over 0xFFFFFFFF -> word1=0xFF34FF78 after AW captured.
REQ-028 BREADY held 0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout; second write accepted only after B handshake.
REQ-029 STATUS_I=0xA5A5_0001, read 0x1C -> RDATA=0xA5A50001; write 0x1C -> BRESP=10 with AXIL_SLV_RESP_ERR_EN, 00 without, and readback still STATUS_I.
REQ-030 Word2=0x11111111, write 0x22222222 commit on same edge as read handshake at 0x08 -> RDATA=0x11111111; next read -> 0x22222222.
REQ-031 Assert reset while BVALID=1 -> BVALID=0, CTRL_O=0 next edge, no B response after release.
